// File: rtl/nit_row_selector.sv
// nit_row_selector: scans one cartridge row column by column, majority-votes each nit and
// presents the row to the ROM buffer. Define ROW_PARITY_EN to scan and check a parity column.
module nit_row_selector #(
    parameter int COLUMNS       = 8,
    parameter int COL_BITS      = 3,
    parameter int SETTLE_CYCLES = 256,
    parameter int SAMPLES       = 5,
    parameter int ROWS          = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startSelector,
    input  logic                sensorIn,
    output logic [COL_BITS-1:0] columnSelect,
    output logic                emitterEn,
    output logic [COLUMNS-1:0]  rowData,
    output logic [4:0]          rowAddr,
    output logic                rowValid,
    output logic                selectorComplete,
    output logic                busy,
    output logic                parityError
);

`ifdef ROW_PARITY_EN
    localparam int SCAN_COLS = COLUMNS + 1;
`else
    localparam int SCAN_COLS = COLUMNS;
`endif
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, STORE, WRITE, DONE} selectorState;
    selectorState state, stateNext;

    logic                 sensorSync_p0, sensorSync_p1;
    logic                 startPrev, startEdge;
    logic [CNT_W-1:0]     cycleCnt;
    logic [3:0]           onesCnt;
    logic [SCAN_COLS-1:0] rowAcc, rowAccNext;
    logic                 nitVote, lastCol, settleDone, sampleDone;

    function automatic logic majority(input logic [3:0] ones);
        return ones > 4'(SAMPLES / 2);
    endfunction

    assign nitVote    = majority(onesCnt);
    assign lastCol    = (columnSelect == COL_BITS'(SCAN_COLS - 1));
    assign settleDone = (cycleCnt == CNT_W'(SETTLE_CYCLES - 1));
    assign sampleDone = (cycleCnt == CNT_W'(SAMPLES - 1));
    assign rowAccNext = rowAcc | (SCAN_COLS'(nitVote) << columnSelect);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext        = state;
        rowValid         = 1'b0;
        selectorComplete = 1'b0;
        busy             = (state != IDLE);
        emitterEn        = 1'b0;
        case (state)
            IDLE:   if (startEdge) stateNext = SETTLE;
            SETTLE: begin
                emitterEn = 1'b1;
                if (settleDone) stateNext = SAMPLE;
            end
            SAMPLE: begin
                emitterEn = 1'b1;
                if (sampleDone) stateNext = STORE;
            end
            STORE: begin
                emitterEn = 1'b1;
                stateNext = lastCol ? WRITE : SETTLE;
            end
            WRITE: begin
                rowValid  = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                selectorComplete = 1'b1;
                stateNext        = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensorSync_p0 <= 1'b0;
            sensorSync_p1 <= 1'b0;
            startPrev     <= 1'b0;
            startEdge     <= 1'b0;
            cycleCnt      <= '0;
            onesCnt       <= '0;
            rowAcc        <= '0;
            columnSelect  <= '0;
            rowData       <= '0;
            rowAddr       <= '0;
`ifdef ROW_PARITY_EN
            parityError   <= 1'b0;
`endif
        end else begin
            sensorSync_p0 <= sensorIn;
            sensorSync_p1 <= sensorSync_p0;
            startPrev     <= startSelector;
            startEdge     <= startSelector & ~startPrev;
            case (state)
                IDLE: if (startEdge) begin
                    columnSelect <= '0;
                    rowAcc       <= '0;
                    cycleCnt     <= '0;
                    onesCnt      <= '0;
                end
                SETTLE: cycleCnt <= settleDone ? '0 : cycleCnt + CNT_W'(1);
                SAMPLE: begin
                    onesCnt  <= onesCnt + {3'b000, sensorSync_p1};
                    cycleCnt <= sampleDone ? '0 : cycleCnt + CNT_W'(1);
                end
                STORE: begin
                    onesCnt <= '0;
                    rowAcc  <= rowAccNext;
                    // Output row and parity are loaded together so both are valid with rowValid.
                    if (lastCol) begin
                        rowData <= rowAccNext[COLUMNS-1:0];
`ifdef ROW_PARITY_EN
                        parityError <= ^rowAccNext;
`endif
                    end else begin
                        columnSelect <= columnSelect + COL_BITS'(1);
                    end
                end
                DONE: rowAddr <= (rowAddr == 5'(ROWS - 1)) ? 5'd0 : rowAddr + 5'd1;
                default: ;
            endcase
        end
    end

`ifndef ROW_PARITY_EN
    assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_nit_row_selector.sv
// Directed bench for nit_row_selector: a column-addressed sensor model plus pulse monitors.
module tb_nit_row_selector;

`ifdef ROW_PARITY_EN
    localparam int COL_BITS  = 4;
    localparam int SCAN_COLS = 9;
`else
    localparam int COL_BITS  = 3;
    localparam int SCAN_COLS = 8;
`endif
    localparam int LATENCY = SCAN_COLS * (256 + 5 + 1) + 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                startSelector = 1'b0;
    logic                sensorIn = 1'b0;
    logic [COL_BITS-1:0] columnSelect;
    logic                emitterEn;
    logic [7:0]          rowData;
    logic [4:0]          rowAddr;
    logic                rowValid;
    logic                selectorComplete;
    logic                busy;
    logic                parityError;

    nit_row_selector #(.COL_BITS(COL_BITS)) dut (
        .clk(clk), .reset(reset), .startSelector(startSelector), .sensorIn(sensorIn),
        .columnSelect(columnSelect), .emitterEn(emitterEn), .rowData(rowData), .rowAddr(rowAddr),
        .rowValid(rowValid), .selectorComplete(selectorComplete), .busy(busy), .parityError(parityError)
    );

    always #5 clk = ~clk;

    // Sensor model: mode 0 reads the pattern at the addressed column; mode 1 replaces
    // columns 2 and 3 with toggles giving 3/5 and 2/5 ones inside the sample window.
    logic [7:0]          sensorPattern = 8'h00;
    logic                parityNit = 1'b0;
    int                  sensorMode = 0;
    int                  colAge = 0;
    logic [COL_BITS-1:0] lastColSeen = '0;

    always @(negedge clk) begin
        if (columnSelect != lastColSeen) begin
            colAge      = 0;
            lastColSeen = columnSelect;
        end else begin
            colAge++;
        end
        if (int'(columnSelect) >= 8)
            sensorIn = parityNit;
        else if (sensorMode == 1 && int'(columnSelect) == 2)
            sensorIn = (colAge == 254 || colAge == 256 || colAge == 258);
        else if (sensorMode == 1 && int'(columnSelect) == 3)
            sensorIn = (colAge == 255 || colAge == 257);
        else
            sensorIn = sensorPattern[columnSelect[2:0]];
    end

    int         validCount = 0;
    int         completeCount = 0;
    logic [7:0] lastRowData = 8'h00;
    logic [4:0] lastRowAddr = 5'd0;
    logic       lastParity = 1'b0;

    always @(negedge clk) begin
        if (rowValid === 1'b1) begin
            validCount++;
            lastRowData = rowData;
            lastRowAddr = rowAddr;
            lastParity  = parityError;
        end
        if (selectorComplete === 1'b1) completeCount++;
    end

    int checks = 0;
    int failures = 0;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        @(negedge clk); startSelector = 1'b1;
        @(negedge clk); startSelector = 1'b0;
    endtask

    task automatic waitComplete(input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (selectorComplete === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic doScan(input string tag);
        int cyc;
        pulseStart();
        waitComplete(LATENCY + 50, cyc);
        checkValue({tag, "_finished"}, 32'(cyc > 0), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int         lat;
        int         v0, c0, vStart, cStart;
        int         found;
        logic [7:0] pattern;
        logic [4:0] expAddr;
        logic       expParity;

        // Reset state
        repeat (3) @(negedge clk);
        checkValue("rst_columnSelect", 32'(columnSelect), 32'd0);
        checkValue("rst_emitterEn", 32'(emitterEn), 32'd0);
        checkValue("rst_rowData", 32'(rowData), 32'd0);
        checkValue("rst_rowAddr", 32'(rowAddr), 32'd0);
        checkValue("rst_rowValid", 32'(rowValid), 32'd0);
        checkValue("rst_selectorComplete", 32'(selectorComplete), 32'd0);
        checkValue("rst_busy", 32'(busy), 32'd0);
        checkValue("rst_parityError", 32'(parityError), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: pattern 0xA5, exact latency, single-cycle completion
        vStart = validCount; cStart = completeCount;
        sensorPattern = 8'hA5; sensorMode = 0;
        @(negedge clk); startSelector = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= LATENCY + 50; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin
                startSelector = 1'b0;
                checkValue("scan_busy", 32'(busy), 32'd1);
                checkValue("scan_emitterEn", 32'(emitterEn), 32'd1);
            end
            if (selectorComplete === 1'b1) begin
                lat = n;
                break;
            end
        end
        checkValue("latency", 32'(lat), 32'(LATENCY));
        @(posedge clk); #1;
        checkValue("complete_width", 32'(selectorComplete), 32'd0);
        repeat (2) @(posedge clk);
        checkValue("t1_rowData", 32'(lastRowData), 32'hA5);
        checkValue("t1_rowAddr", 32'(lastRowAddr), 32'd0);
        checkValue("t1_rowData_held", 32'(rowData), 32'hA5);
        checkValue("t1_rowAddr_next", 32'(rowAddr), 32'd1);
        checkValue("t1_emitter_off", 32'(emitterEn), 32'd0);
        checkValue("t1_idle", 32'(busy), 32'd0);
        checkValue("t1_valid_count", 32'(validCount - vStart), 32'd1);
        checkValue("t1_complete_count", 32'(completeCount - cStart), 32'd1);

        // Test 2: majority vote on toggling sensor (col2 3/5 ones, col3 2/5 ones)
        sensorPattern = 8'hC9; sensorMode = 1;
        doScan("t2");
        checkValue("t2_rowData", 32'(lastRowData), 32'hC5);
        checkValue("t2_rowAddr", 32'(lastRowAddr), 32'd1);
        sensorMode = 0;

        // Test 3: start held high with extra edges mid-scan
        v0 = validCount; c0 = completeCount;
        sensorPattern = 8'h3C;
        @(negedge clk); startSelector = 1'b1;
        repeat (500) @(negedge clk);
        startSelector = 1'b0;
        @(negedge clk); startSelector = 1'b1;
        repeat (1000) @(negedge clk);
        startSelector = 1'b0;
        @(negedge clk); startSelector = 1'b1;
        repeat (1498) @(negedge clk);
        startSelector = 1'b0;
        repeat (50) @(posedge clk);
        checkValue("t3_valid_count", 32'(validCount - v0), 32'd1);
        checkValue("t3_complete_count", 32'(completeCount - c0), 32'd1);
        checkValue("t3_rowData", 32'(lastRowData), 32'h3C);
        checkValue("t3_rowAddr", 32'(lastRowAddr), 32'd2);
        checkValue("t3_idle", 32'(busy), 32'd0);

        // Test 4 (+ parity rows): scans continue to 33 total, rowAddr wraps 31 -> 0
        for (int i = 0; i < 30; i++) begin
            pattern       = (i < 2) ? 8'h07 : 8'(i * 37 + 1);
            parityNit     = 1'(i);
            sensorPattern = pattern;
            expAddr       = 5'((3 + i) % 32);
`ifdef ROW_PARITY_EN
            expParity = (^pattern) ^ parityNit;
`else
            expParity = 1'b0;
`endif
            doScan("t4");
            checkValue("t4_rowData", 32'(lastRowData), 32'(pattern));
            checkValue("t4_rowAddr", 32'(lastRowAddr), 32'(expAddr));
            checkValue("t4_parityError", 32'(lastParity), 32'(expParity));
        end
        parityNit = 1'b0;
        checkValue("t4_complete_total", 32'(completeCount - cStart), 32'd33);
        checkValue("t4_valid_total", 32'(validCount - vStart), 32'd33);
        checkValue("t4_rowAddr_wrapped", 32'(rowAddr), 32'd1);

        // Test 5: reset during SAMPLE of column 4, then a clean scan
        v0 = validCount; c0 = completeCount;
        sensorPattern = 8'hFF;
        pulseStart();
        found = 0;
        for (int n = 0; n < LATENCY && found == 0; n++) begin
            @(negedge clk);
            if (columnSelect == COL_BITS'(4)) found = 1;
        end
        checkValue("t5_col4_reached", 32'(found), 32'd1);
        repeat (258) @(negedge clk);
        reset = 1'b1;
        #1;
        checkValue("t5_columnSelect", 32'(columnSelect), 32'd0);
        checkValue("t5_emitterEn", 32'(emitterEn), 32'd0);
        checkValue("t5_rowData", 32'(rowData), 32'd0);
        checkValue("t5_rowAddr", 32'(rowAddr), 32'd0);
        checkValue("t5_busy", 32'(busy), 32'd0);
        checkValue("t5_parityError", 32'(parityError), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        checkValue("t5_no_partial_valid", 32'(validCount - v0), 32'd0);
        checkValue("t5_no_complete", 32'(completeCount - c0), 32'd0);
        sensorPattern = 8'h5A;
        doScan("t5");
        checkValue("t5_rowData_after", 32'(lastRowData), 32'h5A);
        checkValue("t5_rowAddr_after", 32'(lastRowAddr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
